mac_vector_driver: RTL and testbench
====================================

// Module: mac_vector_driver
// PURPOSE
//  Operand-side driver for the 8-bit accumulating MAC (ports a, b, cin, rst; out[15:0], cout).
//  Accepts operand-pair vectors on a valid/ready stream and clears the MAC at vector start.
//  Feeds one pair per cycle, drains the MAC pipeline, then captures the accumulated dot product.
//  Sits between the operand source (FIFO/controller) and the MAC, replacing bench-style direct driving.
// PARAMETERS
//  MAC_LAT   1    cycles from MAC input change to updated out/cout (registered accumulator)
//  MAX_LEN   255  max pairs per vector; a vector reaching this length is force-terminated
//  CNT_W     8    width of beat counter, >= clog2(MAX_LEN+1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  s_valid    in   1      operand pair valid
//  s_ready    out  1      driver accepts pair this cycle
//  s_a        in   8      multiplicand
//  s_b        in   8      multiplier
//  s_cin      in   1      carry-in added with this pair
//  s_last     in   1      final pair of vector
//  mac_rst    out  1      clear to MAC (drives MAC rst)
//  mac_a      out  8      registered operand to MAC a
//  mac_b      out  8      registered operand to MAC b
//  mac_cin    out  1      registered carry-in to MAC cin
//  mac_out    in   16     MAC accumulator value
//  mac_cout   in   1      MAC carry-out
//  m_valid    out  1      result valid
//  m_ready    in   1      result consumer ready
//  m_sum      out  16     captured accumulator
//  m_ovf      out  1      sticky OR of mac_cout over vector
//  m_count    out  CNT_W  pairs accepted in vector
//  m_trunc    out  1      vector ended by MAX_LEN, not s_last
// BEHAVIOUR
//  Reset: state IDLE; s_ready=0, mac_rst=1, mac_a/b/cin=0, m_valid=0, m_sum=0, m_ovf/m_trunc=0, m_count=0.
//  FSM: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.
//   IDLE: s_ready=0, mac_rst=0. s_valid=1 -> CLEAR.
//   CLEAR: exactly 1 cycle; mac_rst=1, s_ready=0, mac_a/b/cin=0; zero counter and ovf -> STREAM.
//   STREAM: s_ready=1; handshake = s_valid&s_ready.
//    Accept at edge k: mac_a/b/cin <= s_a/s_b/s_cin; count++.
//    No accept: mac_a/b/cin <= 0 (bubble adds zero).
//    Accept with s_last, or count reaching MAX_LEN -> DRAIN; m_trunc = (MAX_LEN && !s_last).
//   DRAIN: s_ready=0; mac_a/b/cin <= 0; hold MAC_LAT+1 cycles (down-counter).
//    Then m_sum <= mac_out -> DONE.
//   DONE: m_valid=1; m_sum/m_ovf/m_count/m_trunc stable until m_valid&m_ready.
//    Then IDLE; no new vector accepted while in DONE.
//  Overflow: m_ovf |= mac_cout every cycle from first post-CLEAR MAC update through capture.
//   m_sum is accumulator mod 2^16.
//  Empty vector impossible: the pair that triggers CLEAR is accepted in STREAM.
//   s_valid must stay high IDLE->STREAM; if it drops, STREAM waits.
//  Zero-product pairs (a or b = 0) count as beats.
//  rst mid-vector: any state -> reset values next edge; partial result discarded; mac_rst=1 clears MAC.
//  Latency: last accept at edge k -> m_valid high from edge k+MAC_LAT+2.
// STRUCTURE
//  Shared package: state encoding constants (IDLE/CLEAR/STREAM/DRAIN/DONE); MAC operand width 8; acc width 16.
//  Single module; no sub-module. Beat and drain counters are plain registers.
// TESTING (bench instantiates driver + VedicKS_8bitMAC)
//  Pairs (3,2,0),(5,1,0),(2,3,0),(3,3,1,last), back-to-back -> m_sum=27, m_count=4, m_ovf=0, m_trunc=0.
//  Single pair (255,255,0,last) -> m_sum=65025. Then (255,255),(22,12,last) in a new vector -> m_sum=65289; prior sum cleared.
//  (255,255),(255,255,last) -> m_sum=64514 (130050 mod 65536), m_ovf=1.
//  s_valid gaps of 3 cycles between (3,2),(5,1,last) -> m_sum=11; bubbles add nothing.
//  m_ready low 5 cycles in DONE -> m_valid and fields held, s_ready=0; release -> IDLE.
//  rst pulse after 2 of 4 pairs -> outputs at reset values; new vector (4,4,last) -> m_sum=16.
//  MAX_LEN=3, 5 pairs of (1,1), no s_last -> m_sum=3, m_count=3, m_trunc=1.

Source files
------------

// File: rtl/mac_vector_driver_pkg.sv
// Shared definitions for the MAC operand driver: FSM state encoding and
// the operand/accumulator widths of the attached 8-bit accumulating MAC.
package mac_vector_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int OP_W  = 8;
    localparam int ACC_W = 16;

endpackage

// File: rtl/mac_vector_driver.sv
// Operand-side driver for an accumulating MAC: clears it at vector start, feeds
// one operand pair per cycle, drains the MAC pipeline and presents the dot product.
module mac_vector_driver
    import mac_vector_driver_pkg::*;
#(
    parameter int MAC_LAT = 1,
    parameter int MAX_LEN = 255,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic        [OP_W-1:0]  s_a,
    input  logic        [OP_W-1:0]  s_b,
    input  logic                    s_cin,
    input  logic                    s_last,
    output logic                    mac_rst,
    output logic        [OP_W-1:0]  mac_a,
    output logic        [OP_W-1:0]  mac_b,
    output logic                    mac_cin,
    input  logic        [ACC_W-1:0] mac_out,
    input  logic                    mac_cout,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic        [ACC_W-1:0] m_sum,
    output logic                    m_ovf,
    output logic        [CNT_W-1:0] m_count,
    output logic                    m_trunc
);

    localparam int DRN_W = $clog2(MAC_LAT + 2);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(MAC_LAT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

    state_t             state, state_d;
    logic               accept;
    logic               end_beat;
    logic [CNT_W-1:0]   cnt;
    logic [DRN_W-1:0]   drn;
    logic [OP_W-1:0]    a_p0, b_p0;
    logic               cin_p0;
    logic [ACC_W-1:0]   sum_p1;
    logic               ovf;
    logic               trunc;
    logic               mac_rst_q;

    function automatic logic is_end_beat(input logic last, input logic [CNT_W-1:0] count);
        return last || (count == LAST_CNT);
    endfunction

    assign accept   = s_valid && s_ready;
    assign end_beat = is_end_beat(s_last, cnt);

    always_comb begin
        state_d = state;
        s_ready = 1'b0;
        m_valid = 1'b0;
        case (state)
            ST_IDLE:   if (s_valid) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = ST_STREAM;
            ST_STREAM: begin
                s_ready = 1'b1;
                if (s_valid && end_beat) state_d = ST_DRAIN;
            end
            ST_DRAIN:  if (drn == '0) state_d = ST_DRAIN == ST_DRAIN ? ST_DONE : ST_DRAIN;
            ST_DONE:   begin
                m_valid = 1'b1;
                if (m_ready) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Stage p0: operand register toward the MAC; bubbles drive zero so idle
    // cycles add nothing to the accumulator. Stage p1: result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mac_rst_q <= 1'b1;
            cnt       <= '0;
            drn       <= '0;
            a_p0      <= '0;
            b_p0      <= '0;
            cin_p0    <= 1'b0;
            sum_p1    <= '0;
            ovf       <= 1'b0;
            trunc     <= 1'b0;
        end else begin
            state     <= state_d;
            mac_rst_q <= (state_d == ST_CLEAR);
            a_p0      <= '0;
            b_p0      <= '0;
            cin_p0    <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    cnt   <= '0;
                    ovf   <= 1'b0;
                    trunc <= 1'b0;
                end
                ST_STREAM: begin
                    ovf <= ovf | mac_cout;
                    if (accept) begin
                        a_p0   <= s_a;
                        b_p0   <= s_b;
                        cin_p0 <= s_cin;
                        cnt    <= cnt + CNT_W'(1);
                        if (end_beat) begin
                            trunc <= !s_last;
                            drn   <= DRN_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    ovf <= ovf | mac_cout;
                    if (drn == '0) sum_p1 <= mac_out;
                    else           drn    <= drn - DRN_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign mac_rst = mac_rst_q;
    assign mac_a   = a_p0;
    assign mac_b   = b_p0;
    assign mac_cin = cin_p0;
    assign m_sum   = sum_p1;
    assign m_ovf   = ovf;
    assign m_count = cnt;
    assign m_trunc = trunc;

endmodule

// File: tb/tb_mac_vector_driver.sv
// Directed bench for mac_vector_driver with a behavioural accumulating MAC
// attached to each driver instance and a queue of expected vector results.
module tb_mac_vector_driver;

    localparam int MAC_LAT  = 1;
    localparam int MAXLEN2  = 3;

    typedef struct {
        int sum;
        int count;
        bit ovf;
        bit trunc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_valid2;
    logic        s_ready, s_ready2;
    logic [7:0]  s_a, s_b;
    logic        s_cin, s_last;
    logic        mac_rst, mac_rst2;
    logic [7:0]  mac_a, mac_b, mac_a2, mac_b2;
    logic        mac_cin, mac_cin2;
    logic [15:0] mac_out, mac_out2;
    logic        mac_cout, mac_cout2;
    logic        m_valid, m_valid2;
    logic        m_ready, m_ready2;
    logic [15:0] m_sum, m_sum2;
    logic        m_ovf, m_ovf2;
    logic [7:0]  m_count, m_count2;
    logic        m_trunc, m_trunc2;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    int   acc_m, cnt_m;
    bit   ovf_m;

    always #5 clk = ~clk;

    mac_vector_driver #(.MAC_LAT(MAC_LAT), .MAX_LEN(255), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .s_cin(s_cin), .s_last(s_last), .mac_rst(mac_rst), .mac_a(mac_a), .mac_b(mac_b),
        .mac_cin(mac_cin), .mac_out(mac_out), .mac_cout(mac_cout), .m_valid(m_valid),
        .m_ready(m_ready), .m_sum(m_sum), .m_ovf(m_ovf), .m_count(m_count), .m_trunc(m_trunc)
    );

    mac_vector_driver #(.MAC_LAT(MAC_LAT), .MAX_LEN(MAXLEN2), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_a(s_a), .s_b(s_b),
        .s_cin(s_cin), .s_last(s_last), .mac_rst(mac_rst2), .mac_a(mac_a2), .mac_b(mac_b2),
        .mac_cin(mac_cin2), .mac_out(mac_out2), .mac_cout(mac_cout2), .m_valid(m_valid2),
        .m_ready(m_ready2), .m_sum(m_sum2), .m_ovf(m_ovf2), .m_count(m_count2), .m_trunc(m_trunc2)
    );

    // Behavioural 8-bit accumulating MAC, one registered stage.
    always_ff @(posedge clk) begin
        if (mac_rst) {mac_cout, mac_out} <= '0;
        else {mac_cout, mac_out} <= {1'b0, mac_out} + 17'(mac_a) * 17'(mac_b) + 17'(mac_cin);
        if (mac_rst2) {mac_cout2, mac_out2} <= '0;
        else {mac_cout2, mac_out2} <= {1'b0, mac_out2} + 17'(mac_a2) * 17'(mac_b2) + 17'(mac_cin2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic begin_vec();
        acc_m = 0;
        cnt_m = 0;
        ovf_m = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic send(input int a, input int b, input bit cin, input bit last);
        int   n;
        int   tmp;
        exp_t e;
        s_valid = 1'b1;
        s_a     = 8'(a);
        s_b     = 8'(b);
        s_cin   = cin;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_wait", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        tmp = acc_m + a * b + int'(cin);
        if (tmp > 65535) ovf_m = 1'b1;
        acc_m = tmp & 16'hFFFF;
        cnt_m++;
        if (last) begin
            e.sum = acc_m; e.count = cnt_m; e.ovf = ovf_m; e.trunc = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic collect(input string tag, input int hold, output int lat);
        int   n;
        exp_t e;
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        chk({tag, "_m_valid"}, m_valid, 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"},   m_sum,   e.sum);
            chk({tag, "_count"}, m_count, e.count);
            chk({tag, "_ovf"},   m_ovf,   e.ovf);
            chk({tag, "_trunc"}, m_trunc, e.trunc);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, m_valid, 1);
                chk({tag, "_hold_sum"},   m_sum,   e.sum);
                chk({tag, "_hold_ready"}, s_ready, 0);
            end
        end
        chk({tag, "_s_ready_done"}, s_ready, 0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk({tag, "_released"}, m_valid, 0);
    endtask

    initial begin
        int   lat;
        int   n;
        int   beats;
        exp_t e;
        rst = 1'b1; s_valid = 1'b0; s_valid2 = 1'b0; s_a = '0; s_b = '0;
        s_cin = 1'b0; s_last = 1'b0; m_ready = 1'b0; m_ready2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_mac_rst", mac_rst, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_sum",   m_sum,   0);
        chk("rst_m_count", m_count, 0);
        chk("rst_mac_a",   mac_a,   0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // back-to-back vector of four pairs
        begin_vec();
        send(3, 2, 0, 0); send(5, 1, 0, 0); send(2, 3, 0, 0); send(3, 3, 1, 1);
        collect("dot4", 0, lat);
        chk("dot4_latency", lat, MAC_LAT + 2);

        // single pair, then a new vector that must start from zero
        begin_vec(); send(255, 255, 0, 1); collect("single", 0, lat);
        begin_vec(); send(255, 255, 0, 0); send(22, 12, 0, 1); collect("cleared", 0, lat);

        // accumulator wrap sets overflow; hold result with m_ready low
        begin_vec(); send(255, 255, 0, 0); send(255, 255, 0, 1); collect("wrap_hold", 5, lat);

        // gaps between pairs are zero bubbles
        begin_vec();
        send(3, 2, 0, 0);
        repeat (3) @(negedge clk);
        send(5, 1, 0, 1);
        collect("gaps", 0, lat);

        // reset in the middle of a vector
        begin_vec();
        send(7, 7, 0, 0); send(9, 9, 1, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_mac_rst", mac_rst, 1);
        chk("midrst_mac_a",   mac_a,   0);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_sum",   m_sum,   0);
        chk("midrst_m_count", m_count, 0);
        rst = 1'b0;
        @(negedge clk);
        begin_vec(); send(4, 4, 0, 1); collect("after_rst", 0, lat);

        // forced termination at MAX_LEN on the second instance
        s_a = 8'd1; s_b = 8'd1; s_cin = 1'b0; s_last = 1'b0;
        s_valid2 = 1'b1;
        beats = 0;
        n = 0;
        while (!m_valid2 && n < 60) begin
            if (s_ready2) beats++;
            if (beats >= 5) s_valid2 = 1'b0;
            @(negedge clk);
            n++;
        end
        s_valid2 = 1'b0;
        e.sum = (beats < MAXLEN2 ? beats : MAXLEN2);
        e.count = e.sum; e.ovf = 1'b0; e.trunc = 1'b1;
        sb.push_back(e);
        e = sb.pop_front();
        chk("trunc_m_valid", m_valid2, 1);
        chk("trunc_beats",   beats,    MAXLEN2);
        chk("trunc_sum",     m_sum2,   e.sum);
        chk("trunc_count",   m_count2, e.count);
        chk("trunc_ovf",     m_ovf2,   e.ovf);
        chk("trunc_flag",    m_trunc2, e.trunc);
        m_ready2 = 1'b1;
        @(negedge clk);
        m_ready2 = 1'b0;
        chk("trunc_released", m_valid2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
